// File: rtl/dff_edge_qual.sv
// Multi-channel edge qualifier: optional input synchroniser, then a per-channel debounce FSM.
// Emits registered rise, fall, any-edge and glitch pulses, a sticky glitch flag and the debounced level.
module dff_edge_qual #(
  parameter int N          = 4,
  parameter int STABLE_CNT = 3,
  parameter int SYNC       = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic [N-1:0] clr,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic [N-1:0] f,
  output logic [N-1:0] x,
  output logic [N-1:0] g,
  output logic [N-1:0] gs
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CNT);

  typedef enum logic [1:0] {S_LOW, S_RPEND, S_HIGH, S_FPEND} state_t;

  logic [N-1:0] s;

  generate
    if (SYNC == 0) begin : g_nosync
      assign s = din;
    end else begin : g_sync
      logic [N-1:0] chain [SYNC];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < SYNC; j++) chain[j] <= '0;
        end else begin
          chain[0] <= din;
          for (int j = 1; j < SYNC; j++) chain[j] <= chain[j-1];
        end
      end
      assign s = chain[SYNC-1];
    end
  endgenerate

  state_t        st_q  [N];
  state_t        st_n  [N];
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_n [N];
  logic [N-1:0]  q_n, r_n, f_n, x_n, g_n, gs_n;

  always_comb begin
    st_n  = st_q;
    cnt_n = cnt_q;
    q_n   = q;
    r_n   = '0;
    f_n   = '0;
    g_n   = '0;
    for (int i = 0; i < N; i++) begin
      case (st_q[i])
        S_LOW: begin
          if (s[i]) begin
            if (STABLE_CNT == 1) begin
              st_n[i] = S_HIGH;
              q_n[i]  = 1'b1;
              r_n[i]  = 1'b1;
            end else begin
              st_n[i]  = S_RPEND;
              cnt_n[i] = CW'(1);
            end
          end
        end
        S_RPEND: begin
          if (!s[i]) begin
            st_n[i]  = S_LOW;
            cnt_n[i] = '0;
            g_n[i]   = 1'b1;
          end else if (cnt_q[i] == CNT_LAST) begin
            st_n[i]  = S_HIGH;
            cnt_n[i] = '0;
            q_n[i]   = 1'b1;
            r_n[i]   = 1'b1;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_n[i] = cnt_q[i] + CW'(1);
          end
        end
        S_HIGH: begin
          if (!s[i]) begin
            if (STABLE_CNT == 1) begin
              st_n[i] = S_LOW;
              q_n[i]  = 1'b0;
              f_n[i]  = 1'b1;
            end else begin
              st_n[i]  = S_FPEND;
              cnt_n[i] = CW'(1);
            end
          end
        end
        S_FPEND: begin
          if (s[i]) begin
            st_n[i]  = S_HIGH;
            cnt_n[i] = '0;
            g_n[i]   = 1'b1;
          end else if (cnt_q[i] == CNT_LAST) begin
            st_n[i]  = S_LOW;
            cnt_n[i] = '0;
            q_n[i]   = 1'b0;
            f_n[i]   = 1'b1;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_n[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          st_n[i]  = S_LOW;
          cnt_n[i] = '0;
        end
      endcase
    end
    x_n  = r_n | f_n;
    // A glitch being raised or currently visible on g overrides a clear.
    gs_n = g_n | g | (gs & ~clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        st_q[i]  <= S_LOW;
        cnt_q[i] <= '0;
      end
      q  <= '0;
      r  <= '0;
      f  <= '0;
      x  <= '0;
      g  <= '0;
      gs <= '0;
    end else begin
      st_q  <= st_n;
      cnt_q <= cnt_n;
      q     <= q_n;
      r     <= r_n;
      f     <= f_n;
      x     <= x_n;
      g     <= g_n;
      gs    <= gs_n;
    end
  end

endmodule

// File: tb/tb_dff_edge_qual.sv
// Directed bench for dff_edge_qual (N=4, STABLE_CNT=3, SYNC=2): cycle vector table plus reset sequences.
module tb_dff_edge_qual;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din, clr;
  logic [3:0] q, r, f, x, g, gs;

  int total = 0;
  int bad   = 0;

  dff_edge_qual #(.N(4), .STABLE_CNT(3), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .din(din), .clr(clr),
    .q(q), .r(r), .f(f), .x(x), .g(g), .gs(gs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din, clr, q, r, f, g, gs;
  } vec_t;

  vec_t vt [$];

  function automatic void add(input logic [3:0] d, input logic [3:0] c,
                              input logic [3:0] eq, input logic [3:0] er,
                              input logic [3:0] ef, input logic [3:0] eg,
                              input logic [3:0] egs);
    vec_t v;
    v.din = d; v.clr = c; v.q = eq; v.r = er; v.f = ef; v.g = eg; v.gs = egs;
    vt.push_back(v);
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got q/r/f/x/g/gs=%h required %h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] pack_exp(input vec_t v);
    return {v.q, v.r, v.f, v.r | v.f, v.g, v.gs};
  endfunction

  initial begin
    int pulses;
    // Phase A: idle after reset.
    for (int k = 0; k < 10; k++) add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Phase B: clean rise on ch0, captured at edge 1, committed at edge 5.
    for (int k = 1; k <= 4; k++) add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 6; k <= 10; k++) add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Phase C: 2-cycle pulse on ch1 -> glitch, then clear of the sticky flag.
    add(4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Phase D: ch2 rises, 1-cycle low glitch while high, then a real fall.
    for (int k = 1; k <= 4; k++) add(4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0101, 4'b0000, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    add(4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    for (int k = 13; k <= 16; k++) add(4'b0001, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    // Phase E: ch0 falls while ch3 glitches; clr3 while g3 is high; then simultaneous rises.
    add(4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    add(4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b1100);
    add(4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100);
    for (int k = 8; k <= 11; k++) add(4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100);
    add(4'b1001, 4'b0000, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b1100);
    add(4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1100);

    // Reset with din low; outputs must be clear asynchronously and across 2 edges.
    rst = 1'b1; din = '0; clr = '0;
    #1;
    check("rst_async_start", {q, r, f, x, g, gs}, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held", {q, r, f, x, g, gs}, 24'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vt.size(); k++) begin
      @(negedge clk);
      din = vt[k].din;
      clr = vt[k].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), {q, r, f, x, g, gs}, pack_exp(vt[k]));
    end

    // Settle low, then put ch0 into rise-pending with cnt=1 and reset asynchronously.
    @(negedge clk);
    din = '0; clr = '0;
    repeat (8) @(negedge clk);
    din = 4'b0001;
    repeat (3) @(posedge clk);
    #2;
    check("pend_before_rst_q", {q, 20'h0}, 24'h0);
    rst = 1'b1;
    #1;
    check("rst_mid_pending", {q, r, f, x, g, gs}, 24'h0);
    @(posedge clk);
    #1;
    check("rst_mid_pending_hold", {q, r, f, x, g, gs}, 24'h0);
    @(negedge clk);
    rst = 1'b0;

    // First post-reset edge captures din; r[0] expected on the 5th edge only.
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (r[0]) pulses++;
      check($sformatf("post_rst_edge%0d", k), {20'h0, q[0], r[0], x[0], f[0]},
            {20'h0, (k >= 5) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0, 1'b0});
    end
    check("post_rst_pulse_count", 24'(pulses), 24'd1);
    check("post_rst_other_ch", {q[3:1], r[3:1], f[3:1], g, gs, 6'h0}, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
